uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width, parity,
//  stop bits and oversampling; per-frame parity/framing error flags, break detection, and an
//  output FIFO with valid/ready handshake plus overrun indication. Sits between the board RX pin and
//  the command/data consumer logic.
// PARAMETERS
//  CLOCK_RATE  100_000_000  system clock frequency, Hz
//  BAUD_RATE   9600         line rate, baud
//  DATA_BITS   8            data bits per frame, 5..9, LSB first
//  PARITY      0            0 none, 1 even, 2 odd
//  STOP_BITS   1            1 or 2
//  OVERSAMPLE  16           sample ticks per bit, even, >=8
//  FIFO_DEPTH  4            output FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1          system clock, all logic on posedge
//  rst_n          in   1          asynchronous active-low reset
//  rx             in   1          serial line, idle high, asynchronous to clk
//  rx_data_out    out  DATA_BITS  FIFO head data, valid while rx_valid_out=1
//  rx_parity_err  out  1          FIFO head flag: parity mismatch (0 when PARITY=0)
//  rx_frame_err   out  1          FIFO head flag: any stop bit sampled 0
//  rx_valid_out   out  1          FIFO non-empty
//  rx_ready_in    in   1          consumer accepts head when rx_valid_out & rx_ready_in
//  rx_overrun     out  1          1-cycle pulse: completed frame dropped, FIFO full
//  rx_break       out  1          1-cycle pulse: break condition detected
//  rx_busy        out  1          1 in every state except IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0, sync/majority regs=1.
//  - Input: 2-FF synchroniser, then 3-sample majority over consecutive clk samples -> line.
//  - Tick gen: DIV=CLOCK_RATE/(BAUD_RATE*OVERSAMPLE); elaboration $error if DIV<2. Counter
//    0..DIV-1, tick on DIV-1; counter and tick count cleared on IDLE->START.
//  - FSM: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
//    IDLE: line=0 -> START. START: at tick OVERSAMPLE/2-1 sample; 1 -> IDLE (glitch, nothing
//    recorded), 0 -> DATA. Each later bit sampled every OVERSAMPLE ticks (bit centre).
//    DATA: shift in DATA_BITS bits LSB first -> PARITY if PARITY!=0 else STOP.
//    PARITY: perr = ^{data,pbit} ^ (PARITY==2) ... i.e. even: XOR of data+pbit must be 0; odd: 1.
//    STOP: sample STOP_BITS bits; ferr if any is 0. After last stop sample:
//      data==0 & all stop bits 0 (& pbit 0 if present) -> break: pulse rx_break, no push, BREAK_WAIT;
//      else push {ferr,perr,data} -> IDLE (resync from mid-stop bit).
//    BREAK_WAIT: stay until line=1, then IDLE.
//  - Push latency: rx_valid_out rises the cycle after the last stop sample when FIFO was empty.
//  - FIFO: show-ahead; head outputs registered, stable while rx_valid_out & !rx_ready_in.
//    Pop on rx_valid_out & rx_ready_in. Full+push+pop same cycle: both occur, no overrun.
//    Full+push without pop: frame dropped, rx_overrun pulses, FIFO contents unchanged.
//    Empty+push+pop same cycle: pop ignored (nothing valid yet); push lands.
//  - Outputs when FIFO empty: rx_data_out/flags hold last value (don't-care), rx_valid_out=0.
//  - rst_n low mid-frame: frame discarded, FIFO flushed, pending pulses cleared.
//  - Width rules: tick counter $clog2(DIV), sample counter $clog2(OVERSAMPLE), bit counter
//    $clog2(DATA_BITS+1); FIFO pointers $clog2(FIFO_DEPTH)+1 (wrap bit for full/empty).
// STRUCTURE
//  - Package uart_pkg: PARITY_NONE/EVEN/ODD constants, rx FSM state encoding, helper fn for DIV.
//  - Sub-module uart_rx_fifo (width DATA_BITS+2, depth FIFO_DEPTH, async active-low reset,
//    outputs full/empty); synchroniser, tick gen and FSM stay in uart_rx_cfg.
// TESTING  (CLOCK_RATE=32_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 -> DIV=2, 32 clk/bit)
//  1 8N1, ready=1, send 0xA5 -> one valid beat, data 0xA5, perr=0, ferr=0; DATA_BITS=9: 0x1A5 -> 0x1A5.
//  2 PARITY=1, send 0x03 with pbit=1 -> data 0x03, perr=1; pbit=0 -> perr=0; PARITY=2 inverse.
//  3 8N1 0x55 with stop=0 -> data 0x55, ferr=1; line held 0 for 12 bit times -> rx_break one pulse,
//    no FIFO push, rx_busy=1 until line high, then next 0x3C received cleanly.
//  4 ready=0, send 5 frames 0x01..0x05 -> 4 queued, rx_overrun pulse at 5th; drain -> 0x01..0x04 in order.
//  5 low glitch of 200 ns (6 clk) on idle line -> no push, no flags, rx_busy back to 0 within 1 bit.
//  6 rst_n low during data bit 3 -> outputs 0 immediately, FIFO empty; after release 0x3C received once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and the clock divider helper.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } rx_state_e;

   // System clocks per oversample tick.
   function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
      return clock_rate / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead output FIFO for received frames. The head entry is presented
// straight from the storage flops, so it stays put until it is popped.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             pop_en;
   logic             wr_en;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
   assign pop_en   = pop && !empty;
   assign wr_en    = push && (!full || pop_en);
   assign pop_data = mem_q[rd_ptr_q[PTR_W-2:0]];

   // Pointer advance and storage write; a write into a full FIFO is only
   // allowed when the head is leaving in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[PTR_W-2:0]] = push_data;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Storage and pointer registers, flushed on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: input synchroniser with majority filter,
// oversample tick generator, frame FSM with parity/framing/break detection,
// and an output FIFO with valid/ready handshake.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid_out,
   input  logic                 rx_ready_in,
   output logic                 rx_overrun,
   output logic                 rx_break,
   output logic                 rx_busy
);

   localparam int DIV    = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
   localparam int DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int HALF   = OVERSAMPLE / 2 - 1;
   localparam int FIFO_W = DATA_BITS + 2;

   if (DIV < 2) begin : g_div_check
      $error("uart_rx_cfg: CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) must be at least 2");
   end

   rx_state_e            state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [2:0]           maj_q, maj_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 pbit_q, pbit_d;
   logic                 ferr_q, ferr_d;
   logic                 allz_q, allz_d;
   logic                 break_q, break_d;
   logic                 overrun_q, overrun_d;

   logic                 line;
   logic                 tick;
   logic                 mid_bit;
   logic                 perr;
   logic                 push;
   logic [FIFO_W-1:0]    push_data;
   logic [FIFO_W-1:0]    head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;

   assign line    = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
   assign tick    = (div_cnt_q == DIV_W'(DIV - 1));
   assign mid_bit = tick && (samp_cnt_q == SAMP_W'(OVERSAMPLE - 1));
   assign perr    = (PARITY == PARITY_NONE) ? 1'b0 :
                    ((^{data_q, pbit_q}) ^ (PARITY == PARITY_ODD));
   assign pop     = rx_valid_out && rx_ready_in;

   // Two-flop synchroniser followed by a three-sample history for the majority vote.
   always_comb begin
      sync_d = {sync_q[0], rx};
      maj_d  = {maj_q[1:0], sync_q[1]};
   end

   // Frame sequencing: start validation, data shift, parity, stop and break handling.
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
      samp_cnt_d = mid_bit ? '0 : (tick ? samp_cnt_q + SAMP_W'(1) : samp_cnt_q);
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      pbit_d     = pbit_q;
      ferr_d     = ferr_q;
      allz_d     = allz_q;
      break_d    = 1'b0;
      push       = 1'b0;
      push_data  = {ferr_q, perr, data_q};
      case (state_q)
         ST_IDLE: begin
            div_cnt_d  = '0;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            pbit_d     = 1'b0;
            ferr_d     = 1'b0;
            allz_d     = 1'b1;
            if (!line) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick && (samp_cnt_q == SAMP_W'(HALF))) begin
               samp_cnt_d = '0;
               state_d    = line ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (mid_bit) begin
               data_d = {line, data_q[DATA_BITS-1:1]};
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (mid_bit) begin
               pbit_d  = line;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (mid_bit) begin
               ferr_d = ferr_q | ~line;
               allz_d = allz_q & ~line;
               if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if ((data_q == '0) && allz_d && ((PARITY == PARITY_NONE) || !pbit_q)) begin
                     break_d = 1'b1;
                     state_d = ST_BREAK_WAIT;
                  end else begin
                     push      = 1'b1;
                     push_data = {ferr_d, perr, data_q};
                     state_d   = ST_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_BREAK_WAIT: begin
            if (line) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A completed frame is lost only when the FIFO is full and nothing leaves this cycle.
   always_comb begin
      overrun_d = push && fifo_full && !pop;
   end

   // All receiver state registers; the line history resets to idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sync_q     <= 2'b11;
         maj_q      <= 3'b111;
         div_cnt_q  <= '0;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         pbit_q     <= 1'b0;
         ferr_q     <= 1'b0;
         allz_q     <= 1'b1;
         break_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         maj_q      <= maj_d;
         div_cnt_q  <= div_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         pbit_q     <= pbit_d;
         ferr_q     <= ferr_d;
         allz_q     <= allz_d;
         break_q    <= break_d;
         overrun_q  <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rx_data_out   = head[DATA_BITS-1:0];
   assign rx_parity_err = head[DATA_BITS];
   assign rx_frame_err  = head[DATA_BITS+1];
   assign rx_valid_out  = !fifo_empty;
   assign rx_overrun    = overrun_q;
   assign rx_break      = break_q;
   assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver instances (8N1, 9N1, 8E1, 8O1)
// at 32 clocks per bit, each fed from a shared line driver through a selector.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int CLK_RATE = 32_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int BIT_CLK  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rxLine = 1'b1;
   int   sel = 0;
   logic rdy8 = 1'b1;

   logic rx8, rx9, rxE, rxO;
   logic [7:0] d8, dE, dO;
   logic [8:0] d9;
   logic p8, f8, v8, ov8, br8, busy8;
   logic p9, f9, v9, ov9, br9, busy9;
   logic pE, fE, vE, ovE, brE, busyE;
   logic pO, fO, vO, ovO, brO, busyO;

   int vectors = 0;
   int miscompares = 0;
   int ovCount = 0;
   int brCount = 0;
   logic [31:0] q8[$];
   logic [31:0] q9[$];
   logic [31:0] qE[$];
   logic [31:0] qO[$];

   assign rx8 = (sel == 0) ? rxLine : 1'b1;
   assign rx9 = (sel == 1) ? rxLine : 1'b1;
   assign rxE = (sel == 2) ? rxLine : 1'b1;
   assign rxO = (sel == 3) ? rxLine : 1'b1;

   always #15.625 clk = ~clk;

   uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u8 (
      .clk(clk), .rst_n(rst_n), .rx(rx8), .rx_data_out(d8), .rx_parity_err(p8),
      .rx_frame_err(f8), .rx_valid_out(v8), .rx_ready_in(rdy8), .rx_overrun(ov8),
      .rx_break(br8), .rx_busy(busy8));

   uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(9), .PARITY(0),
                 .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) u9 (
      .clk(clk), .rst_n(rst_n), .rx(rx9), .rx_data_out(d9), .rx_parity_err(p9),
      .rx_frame_err(f9), .rx_valid_out(v9), .rx_ready_in(1'b1), .rx_overrun(ov9),
      .rx_break(br9), .rx_busy(busy9));

   uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) uE (
      .clk(clk), .rst_n(rst_n), .rx(rxE), .rx_data_out(dE), .rx_parity_err(pE),
      .rx_frame_err(fE), .rx_valid_out(vE), .rx_ready_in(1'b1), .rx_overrun(ovE),
      .rx_break(brE), .rx_busy(busyE));

   uart_rx_cfg #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) uO (
      .clk(clk), .rst_n(rst_n), .rx(rxO), .rx_data_out(dO), .rx_parity_err(pO),
      .rx_frame_err(fO), .rx_valid_out(vO), .rx_ready_in(1'b1), .rx_overrun(ovO),
      .rx_break(brO), .rx_busy(busyO));

   // Record every accepted head beat as {ferr, perr, data} and count pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (v8 && rdy8) q8.push_back(32'({f8, p8, d8}));
         if (v9) q9.push_back(32'({f9, p9, d9}));
         if (vE) qE.push_back(32'({fE, pE, dE}));
         if (vO) qO.push_back(32'({fO, pO, dO}));
         if (ov8) ovCount++;
         if (br8) brCount++;
      end
   end

   function automatic logic [31:0] peek(input logic [31:0] q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic driveBit(input logic b);
      rxLine = b;
      waitClk(BIT_CLK);
   endtask

   task automatic idleBits(input int n);
      rxLine = 1'b1;
      waitClk(n * BIT_CLK);
   endtask

   // One frame on the selected receiver: start, data LSB first, optional parity, one stop.
   // The line is left at the stop level so a held-low break can follow directly.
   task automatic applyStimulus(input int target, input logic [8:0] data, input int nbits,
                                input bit hasPar, input bit pbit, input bit stopVal);
      sel = target;
      driveBit(1'b0);
      for (int i = 0; i < nbits; i++) driveBit(data[i]);
      if (hasPar) driveBit(pbit);
      driveBit(stopVal);
   endtask

   initial begin
      #20_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ov0, br0;
      logic [8:0] d;
      @(posedge clk); #1;

      // Reset state
      waitClk(5);
      checkOutput("rst_valid", 32'(v8), 32'h0);
      checkOutput("rst_data", 32'(d8), 32'h0);
      checkOutput("rst_busy", 32'(busy8), 32'h0);
      checkOutput("rst_break", 32'(br8), 32'h0);
      checkOutput("rst_overrun", 32'(ov8), 32'h0);
      rst_n = 1'b1;
      waitClk(5);
      checkOutput("post_rst_busy", 32'(busy8), 32'h0);

      // 8N1 and 9N1 basic frames
      applyStimulus(0, 9'h0A5, 8, 0, 0, 1);
      idleBits(2);
      checkOutput("8n1_count", 32'(q8.size()), 32'd1);
      checkOutput("8n1_A5", peek(q8, 0), 32'h0A5);
      applyStimulus(1, 9'h1A5, 9, 0, 0, 1);
      idleBits(2);
      checkOutput("9n1_count", 32'(q9.size()), 32'd1);
      checkOutput("9n1_1A5", peek(q9, 0), 32'h1A5);

      // Parity: 0x03 has even weight, so even parity wants pbit=0, odd wants pbit=1
      applyStimulus(2, 9'h003, 8, 1, 1, 1); idleBits(2);
      applyStimulus(2, 9'h003, 8, 1, 0, 1); idleBits(2);
      applyStimulus(3, 9'h003, 8, 1, 1, 1); idleBits(2);
      applyStimulus(3, 9'h003, 8, 1, 0, 1); idleBits(2);
      checkOutput("even_count", 32'(qE.size()), 32'd2);
      checkOutput("even_p1", peek(qE, 0), 32'h103);
      checkOutput("even_p0", peek(qE, 1), 32'h003);
      checkOutput("odd_count", 32'(qO.size()), 32'd2);
      checkOutput("odd_p1", peek(qO, 0), 32'h003);
      checkOutput("odd_p0", peek(qO, 1), 32'h103);

      // Framing error followed by a break
      q8.delete();
      br0 = brCount;
      applyStimulus(0, 9'h055, 8, 0, 0, 0);
      waitClk(12 * BIT_CLK);
      checkOutput("brk_pulses", 32'(brCount - br0), 32'd1);
      checkOutput("brk_busy_low", 32'(busy8), 32'h1);
      checkOutput("ferr_count", 32'(q8.size()), 32'd1);
      checkOutput("ferr_55", peek(q8, 0), 32'h255);
      rxLine = 1'b1;
      waitClk(10);
      checkOutput("brk_busy_high", 32'(busy8), 32'h0);
      idleBits(2);
      applyStimulus(0, 9'h03C, 8, 0, 0, 1);
      idleBits(2);
      checkOutput("post_brk_count", 32'(q8.size()), 32'd2);
      checkOutput("post_brk_3C", peek(q8, 1), 32'h03C);

      // Overrun with consumer stalled
      q8.delete();
      ov0 = ovCount;
      rdy8 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 9'(i), 8, 0, 0, 1);
         idleBits(1);
         if (i == 4) checkOutput("ovr_none_at4", 32'(ovCount - ov0), 32'd0);
      end
      idleBits(1);
      checkOutput("ovr_pulses", 32'(ovCount - ov0), 32'd1);
      checkOutput("ovr_valid", 32'(v8), 32'h1);
      checkOutput("ovr_head", 32'(d8), 32'h01);
      rdy8 = 1'b1;
      waitClk(10);
      checkOutput("drain_count", 32'(q8.size()), 32'd4);
      for (int i = 0; i < 4; i++) checkOutput("drain_order", peek(q8, i), 32'(i + 1));
      checkOutput("drain_valid", 32'(v8), 32'h0);

      // Short glitch on an idle line
      q8.delete();
      ov0 = ovCount;
      br0 = brCount;
      sel = 0;
      rxLine = 1'b0;
      waitClk(6);
      rxLine = 1'b1;
      waitClk(2);
      checkOutput("glitch_busy", 32'(busy8), 32'h1);
      waitClk(40);
      checkOutput("glitch_idle", 32'(busy8), 32'h0);
      idleBits(1);
      checkOutput("glitch_nopush", 32'(q8.size()), 32'd0);
      checkOutput("glitch_flags", 32'({ovCount - ov0, brCount - br0}), 32'h0);

      // Reset in the middle of data bit 3 with a queued entry
      rdy8 = 1'b0;
      applyStimulus(0, 9'h011, 8, 0, 0, 1);
      idleBits(1);
      checkOutput("pre_rst_head", 32'(d8), 32'h11);
      d = 9'h077;
      driveBit(1'b0);
      for (int i = 0; i < 3; i++) driveBit(d[i]);
      rxLine = d[3];
      waitClk(16);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(v8), 32'h0);
      checkOutput("midrst_data", 32'(d8), 32'h0);
      checkOutput("midrst_busy", 32'(busy8), 32'h0);
      rxLine = 1'b1;
      waitClk(5);
      rst_n = 1'b1;
      rdy8 = 1'b1;
      q8.delete();
      waitClk(5);
      applyStimulus(0, 9'h03C, 8, 0, 0, 1);
      idleBits(2);
      checkOutput("rst_rx_count", 32'(q8.size()), 32'd1);
      checkOutput("rst_rx_3C", peek(q8, 0), 32'h03C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
